// File: rtl/downstream_cancel_accumulator_pkg.sv
// Shared definitions for the downstream cancel accumulator: default sizes,
// the control FSM encoding and the saturation constant.
package downstream_cancel_accumulator_pkg;

    localparam int CLIENTS_DEF = 32;
    localparam int AMT_W_DEF   = 32;
    localparam int ID_W_DEF    = 5;

    // Wide enough for any supported AMT_W; users slice off the low AMT_W bits.
    localparam logic [63:0] SAT_ALL_ONES = '1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/downstream_cancel_accumulator_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry-out and flags it.
module sat_add
    import downstream_cancel_accumulator_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [AMT_W-1:0] a_i,
    input  logic [AMT_W-1:0] b_i,
    output logic [AMT_W-1:0] sum_o,
    output logic             sat_o
);

    logic [AMT_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o    = full_sum[AMT_W];
    assign sum_o    = sat_o ? SAT_ALL_ONES[AMT_W-1:0] : full_sum[AMT_W-1:0];

endmodule

// File: rtl/downstream_cancel_accumulator.sv
// Per-client accumulator of cancelled quantities with a one-stage write
// pipeline, single-entry clear and a full-table clear sweep.
module downstream_cancel_accumulator
    import downstream_cancel_accumulator_pkg::*;
#(
    parameter int CLIENTS = CLIENTS_DEF,
    parameter int AMT_W   = AMT_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cancel_valid,
    output logic             cancel_ready,
    input  logic [ID_W-1:0]  cancel_client_id,
    input  logic [AMT_W-1:0] cancel_amount,
    input  logic             clear_valid,
    input  logic [ID_W-1:0]  clear_client_id,
    input  logic             clear_all,
    input  logic [ID_W-1:0]  rd_client_id,
    output logic [AMT_W-1:0] rd_cancelled,
    output logic             busy,
    output logic             sat_pulse,
    output logic [15:0]      accepted_count
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic              s1_valid_q;
    logic [ID_W-1:0]   s1_id_q;
    logic [AMT_W-1:0]  s1_amt_q;
    logic [AMT_W-1:0]  table_q [CLIENTS];
    logic [AMT_W-1:0]  table_d [CLIENTS];
    logic [AMT_W-1:0]  rd_q;
    logic              sat_q;
    logic [15:0]       count_q;

    logic              in_run;
    logic              accept;
    logic              clear_hit;
    logic [AMT_W-1:0]  add_sum;
    logic              add_sat;

    assign in_run       = (state_q == ST_RUN);
    assign cancel_ready = in_run && !clear_valid && !clear_all;
    assign accept       = cancel_valid && cancel_ready;
    // A same-edge single clear on the pending entry suppresses the write.
    assign clear_hit    = in_run && clear_valid && (clear_client_id == s1_id_q);

    // Write is one edge after accept, so the table already holds every earlier update.
    sat_add #(.AMT_W(AMT_W)) u_sat_add (
        .a_i   (table_q[s1_id_q]),
        .b_i   (s1_amt_q),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            ST_RUN: begin
                if (clear_all) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end
            end
            ST_SWEEP: begin
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == ID_W'(CLIENTS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            table_d[i] = table_q[i];
        end
        if (s1_valid_q) begin
            table_d[s1_id_q] = add_sum;
        end
        if (in_run && clear_valid) begin
            table_d[clear_client_id] = '0;
        end
        if (!in_run) begin
            table_d[sweep_idx_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sweep_idx_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_amt_q    <= '0;
            rd_q        <= '0;
            sat_q       <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < CLIENTS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            s1_valid_q  <= accept;
            if (accept) begin
                s1_id_q  <= cancel_client_id;
                s1_amt_q <= cancel_amount;
            end
            rd_q    <= table_q[rd_client_id];
            sat_q   <= s1_valid_q && add_sat && !clear_hit;
            count_q <= count_q + 16'(accept);
            for (int i = 0; i < CLIENTS; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign rd_cancelled   = rd_q;
    assign sat_pulse      = sat_q;
    assign busy           = (state_q == ST_SWEEP);
    assign accepted_count = count_q;

endmodule

// File: doc/downstream_cancel_accumulator.md
DOWNSTREAM_CANCEL_ACCUMULATOR -- requirements
Module: downstream_cancel_accumulator

Interface
REQ-001 SHALL have parameters: CLIENTS, default 32, number of client entries; AMT_W, default 32, amount/accumulator width; ID_W, default 5, client id width, equal to log2(CLIENTS).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cancel_valid  input  1  exchange cancel confirmation present.
REQ-005 cancel_ready  output  1  block can accept a cancel this cycle.
REQ-006 cancel_client_id  input  ID_W  client of the cancel.
REQ-007 cancel_amount  input  AMT_W  cancelled quantity, unsigned.
REQ-008 clear_valid  input  1  zero one client entry; single-cycle command, always accepted while RUN.
REQ-009 clear_client_id  input  ID_W  target of clear_valid.
REQ-010 clear_all  input  1  pulse starting a sweep that zeroes every entry.
REQ-011 rd_client_id  input  ID_W  lookup address for the upstream risk stage.
REQ-012 rd_cancelled  output  AMT_W  registered accumulated cancels for rd_client_id.
REQ-013 busy  output  1  high while the clear sweep is running.
REQ-014 sat_pulse  output  1  one-cycle pulse when an update saturated.
REQ-015 accepted_count  output  16  number of cancels accepted; wraps at 16'hFFFF to 0.

Function
REQ-016 SHALL hold a CLIENTS x AMT_W table of accumulated cancelled amounts, one entry per client.
REQ-017 FSM states SHALL be RUN and SWEEP; RUN -> SWEEP on clear_all; SWEEP -> RUN after the entry at index CLIENTS-1 is zeroed.
REQ-018 cancel_ready SHALL be 1 only when state is RUN, clear_valid is 0, and clear_all is 0.
REQ-019 A cancel SHALL be accepted on a rising edge where cancel_valid && cancel_ready are both 1; the client id and amount SHALL be registered into stage S1.
REQ-020 On the next edge, the S1 operation SHALL write table[id] <= table[id] + amount, saturating at all-ones.
REQ-021 Back-to-back cancels, including cancels to the same client, SHALL be accepted every cycle without loss; each write SHALL observe all earlier writes.
REQ-022 On saturation, the entry SHALL be set to {AMT_W{1'b1}} and sat_pulse SHALL be asserted in the same cycle as the write.
REQ-023 rd_cancelled SHALL equal table[rd_client_id] sampled at the edge, giving one-cycle read latency; a write on the same edge is not visible until the following read.
REQ-024 clear_valid in RUN SHALL zero table[clear_client_id] on that edge.
REQ-025 If clear_valid and a pending S1 write target the same entry on the same edge, the clear SHALL win.
REQ-026 In SWEEP, the block SHALL zero one entry per cycle, index 0 to CLIENTS-1, taking CLIENTS cycles.
REQ-027 busy SHALL be 1 for exactly those CLIENTS cycles.
REQ-028 An S1 write pending when clear_all arrives SHALL complete before the sweep.
REQ-029 clear_all asserted during SWEEP SHALL be ignored.
REQ-030 clear_valid asserted during SWEEP SHALL be ignored.
REQ-031 accepted_count SHALL increment once per accepted cancel.

Reset
REQ-032 rst_n low SHALL asynchronously force: all table entries to 0, state to RUN, S1 to empty, rd_cancelled to 0, sat_pulse to 0, busy to 0, and accepted_count to 0.
REQ-033 Reset asserted during a SWEEP or with S1 full SHALL discard that work; there is no resume.
REQ-034 cancel_ready SHALL be 1 in the first cycle after rst_n is released.

Structure
REQ-035 The state enum (RUN, SWEEP), the CLIENTS, AMT_W and ID_W defaults, and the saturation constant SHALL live in the shared downstream package.
REQ-036 The saturating adder SHALL be a sub-module named sat_add, purely combinational, with parameter AMT_W.

Verification
REQ-037 Sequence: reset; cancel (id 3, 100); cancel (id 3, 50) on the next cycle; rd_client_id = 3. Required: rd_cancelled = 150 three cycles after the first accept; accepted_count = 2.
REQ-038 Sequence: preload id 7 to 32'hFFFFFFF0; cancel (id 7, 32). Required: entry = 32'hFFFFFFFF; sat_pulse high for 1 cycle.
REQ-039 Sequence: cancel (id 9, 10) accepted, then clear_valid id 9 on the next edge. Required: rd_cancelled for id 9 = 0.
REQ-040 Sequence: fill ids 0..31 with value 5; pulse clear_all. Required: busy high for 32 cycles; cancel_ready low throughout; all entries read 0 afterwards.
REQ-041 Sequence: drop rst_n mid-SWEEP at index 12. Required: busy = 0 and all entries = 0 immediately; after release, cancel_ready = 1.
REQ-042 Sequence: drive 65536 accepted cancels. Required: accepted_count wraps to 0.
